exception_handling: RTL and testbench

Exception detection and capture unit for the CPU datapath. It monitors the ALU overflow flag and the decoder's undefined-opcode flag. On a detected exception it raises a one-cycle flush/redirect request, records the cause and the faulting PC, and holds a pending state until the control unit acknowledges. It sits between the ALU/decoder and the PC-select/pipeline-flush logic.

---
 rtl/exception_handling_pkg.sv | 26 ++
 rtl/exception_handling.sv | 106 ++++++++++
 tb/tb_exception_handling.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/exception_handling_pkg.sv
// ---------------------------------------------------------------------------
// exception_handling_pkg
//   Shared CPU definitions: exception cause encodings, the default handler
//   vector and the exception FSM state type.
// ---------------------------------------------------------------------------
`default_nettype none

package exception_handling_pkg;

  // Exception cause encodings (11 is reserved and never produced)
  localparam logic [1:0] CAUSE_NONE       = 2'b00;
  localparam logic [1:0] CAUSE_ILLEGAL_OP = 2'b01;
  localparam logic [1:0] CAUSE_OVF        = 2'b10;

  // Fixed exception-handler entry point
  localparam logic [31:0] HANDLER_ADDR_DEFAULT = 32'h8000_0180;

  // Exception capture FSM
  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_PEND = 1'b1
  } exc_state_e;

endpackage : exception_handling_pkg

`default_nettype wire

// File: rtl/exception_handling.sv
// ---------------------------------------------------------------------------
// exception_handling
//   Detects ALU overflow / illegal-opcode exceptions, raises a one-cycle
//   flush/redirect pulse, captures cause and faulting PC, and holds a
//   pending state until the control unit acknowledges.
// ---------------------------------------------------------------------------
`default_nettype none

module exception_handling
  import exception_handling_pkg::*;
#(
  parameter int                  PC_WIDTH     = 32,
  parameter logic [PC_WIDTH-1:0] HANDLER_ADDR = PC_WIDTH'(HANDLER_ADDR_DEFAULT)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                ovf,
  input  logic                opcode,
  input  logic [PC_WIDTH-1:0] pc_in,
  input  logic                exc_ack,
  output logic                exception_output,
  output logic                exc_pending,
  output logic [1:0]          exc_cause,
  output logic [PC_WIDTH-1:0] epc,
  output logic [PC_WIDTH-1:0] handler_pc
);

  exc_state_e          state_q, state_d;
  logic                pulse_q, pulse_d;
  logic [1:0]          cause_q, cause_d;
  logic [PC_WIDTH-1:0] epc_q,   epc_d;
  logic [1:0]          cause_sel;
  logic                flag;

  assign flag = ovf | opcode;

  // Priority cause encoder: an illegal opcode outranks an ALU overflow
  always_comb begin
    cause_sel = CAUSE_NONE;
    if (opcode) begin
      cause_sel = CAUSE_ILLEGAL_OP;
    end else if (ovf) begin
      cause_sel = CAUSE_OVF;
    end
  end

  // Next-state logic: capture when idle, or when an ack frees the slot on
  // the same edge a new exception arrives (ack first, then re-capture)
  always_comb begin
    state_d = state_q;
    pulse_d = 1'b0;
    cause_d = cause_q;
    epc_d   = epc_q;
    unique case (state_q)
      ST_IDLE: begin
        if (flag) begin
          state_d = ST_PEND;
          pulse_d = 1'b1;
          cause_d = cause_sel;
          epc_d   = pc_in;
        end
      end
      ST_PEND: begin
        if (exc_ack) begin
          if (flag) begin
            state_d = ST_PEND;
            pulse_d = 1'b1;
            cause_d = cause_sel;
            epc_d   = pc_in;
          end else begin
            state_d = ST_IDLE;
            cause_d = CAUSE_NONE;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        cause_d = CAUSE_NONE;
      end
    endcase
  end

  // State and capture registers; reset aborts any pending exception at once
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      pulse_q <= 1'b0;
      cause_q <= CAUSE_NONE;
      epc_q   <= '0;
    end else begin
      state_q <= state_d;
      pulse_q <= pulse_d;
      cause_q <= cause_d;
      epc_q   <= epc_d;
    end
  end

  assign exception_output = pulse_q;
  assign exc_pending      = (state_q == ST_PEND);
  assign exc_cause        = cause_q;
  assign epc              = epc_q;
  assign handler_pc       = HANDLER_ADDR;

endmodule : exception_handling

`default_nettype wire

// File: tb/tb_exception_handling.sv
// ---------------------------------------------------------------------------
// tb_exception_handling
//   Directed self-checking bench for exception_handling.
// ---------------------------------------------------------------------------
`default_nettype none

module tb_exception_handling;

  logic        clk;
  logic        rst_n;
  logic        ovf;
  logic        opcode;
  logic [31:0] pc_in;
  logic        exc_ack;
  logic        exception_output;
  logic        exc_pending;
  logic [1:0]  exc_cause;
  logic [31:0] epc;
  logic [31:0] handler_pc;

  int checks   = 0;
  int failures = 0;

  exception_handling #(
    .PC_WIDTH    (32),
    .HANDLER_ADDR(32'h8000_0180)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .ovf             (ovf),
    .opcode          (opcode),
    .pc_in           (pc_in),
    .exc_ack         (exc_ack),
    .exception_output(exception_output),
    .exc_pending     (exc_pending),
    .exc_cause       (exc_cause),
    .epc             (epc),
    .handler_pc      (handler_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle just after the rising edge
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic o, input logic op, input logic [31:0] pc, input logic ack);
    ovf     = o;
    opcode  = op;
    pc_in   = pc;
    exc_ack = ack;
  endtask

  task automatic do_reset();
    drive(1'b0, 1'b0, 32'h0, 1'b0);
    rst_n = 1'b0;
    cyc();
    cyc();
    rst_n = 1'b1;
  endtask

  task automatic chk_all(input string tag, input logic p, input logic pend,
                         input logic [1:0] cause, input logic [31:0] pc);
    chk({tag, "_pulse"}, {31'h0, exception_output}, {31'h0, p});
    chk({tag, "_pend"},  {31'h0, exc_pending},      {31'h0, pend});
    chk({tag, "_cause"}, {30'h0, exc_cause},        {30'h0, cause});
    chk({tag, "_epc"},   epc,                       pc);
  endtask

  initial begin
    drive(1'b0, 1'b0, 32'h0, 1'b0);
    rst_n = 1'b0;
    #3;
    // Reset state
    chk_all("reset", 1'b0, 1'b0, 2'b00, 32'h0);
    chk("reset_handler_pc", handler_pc, 32'h8000_0180);
    cyc();
    rst_n = 1'b1;

    // No flags for three cycles
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk_all("quiet", 1'b0, 1'b0, 2'b00, 32'h0);
    end

    // Illegal opcode capture
    drive(1'b0, 1'b1, 32'h40, 1'b0);
    cyc();
    chk_all("illop", 1'b1, 1'b1, 2'b01, 32'h40);
    drive(1'b0, 1'b0, 32'h0, 1'b0);
    cyc();
    chk_all("illop_after", 1'b0, 1'b1, 2'b01, 32'h40);

    // Overflow capture
    do_reset();
    drive(1'b1, 1'b0, 32'h44, 1'b0);
    cyc();
    chk_all("ovf", 1'b1, 1'b1, 2'b10, 32'h44);

    // Both flags: illegal opcode wins, then masking while pending
    do_reset();
    drive(1'b1, 1'b1, 32'h48, 1'b0);
    cyc();
    chk_all("prio", 1'b1, 1'b1, 2'b01, 32'h48);
    drive(1'b1, 1'b0, 32'h4C, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk_all("masked", 1'b0, 1'b1, 2'b01, 32'h48);
    end

    // Ack alone clears pending and cause, epc kept
    drive(1'b0, 1'b0, 32'h50, 1'b1);
    cyc();
    chk_all("ack", 1'b0, 1'b0, 2'b00, 32'h48);
    drive(1'b0, 1'b0, 32'h0, 1'b0);
    cyc();
    chk_all("ack_idle", 1'b0, 1'b0, 2'b00, 32'h48);

    // Capture, then ack together with a new overflow: re-capture
    drive(1'b0, 1'b1, 32'h60, 1'b0);
    cyc();
    chk_all("cap2", 1'b1, 1'b1, 2'b01, 32'h60);
    drive(1'b1, 1'b0, 32'h80, 1'b1);
    cyc();
    chk_all("recap", 1'b1, 1'b1, 2'b10, 32'h80);
    drive(1'b0, 1'b0, 32'h0, 1'b0);
    cyc();
    chk_all("recap_after", 1'b0, 1'b1, 2'b10, 32'h80);

    // Ack while not pending is ignored
    do_reset();
    drive(1'b0, 1'b0, 32'h90, 1'b1);
    cyc();
    chk_all("ack_idle_ignored", 1'b0, 1'b0, 2'b00, 32'h0);

    // Asynchronous reset mid-pending
    drive(1'b1, 1'b0, 32'hA0, 1'b0);
    cyc();
    chk_all("pre_rst", 1'b1, 1'b1, 2'b10, 32'hA0);
    drive(1'b0, 1'b0, 32'h0, 1'b0);
    #1;
    rst_n = 1'b0;
    #1;
    chk_all("async_rst", 1'b0, 1'b0, 2'b00, 32'h0);
    cyc();
    rst_n = 1'b1;
    cyc();
    chk_all("post_rst", 1'b0, 1'b0, 2'b00, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_exception_handling

`default_nettype wire
